// File: rtl/res_pack.sv
// rtl/res_pack.sv - thresholds a 128x128 distance map and packs the result into 16-bit bitmap words
// Address for pixel k is issued one edge before it is sampled; writes fire on the edge completing each word.
module res_pack (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  thr,
  input  logic        hold,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        sti_wr,
  output logic [9:0]  sti_addr,
  output logic [15:0] sti_do,
  output logic [14:0] obj_cnt,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;

  state_t      state_q, state_d;
  logic        rd_q, rd_d;
  logic [13:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [9:0]  waddr_q, waddr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [14:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [14:0] shift_q, shift_d;
  logic        pix_bit;

  assign pix_bit = (res_di > thr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      addr_q  <= 14'd0;
      wr_q    <= 1'b0;
      waddr_q <= 10'd0;
      wdata_q <= 16'd0;
      cnt_q   <= 15'd0;
      done_q  <= 1'b0;
      shift_q <= 15'd0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        state_d = RUN;
        rd_d    = 1'b1;
        addr_d  = 14'd0;
      end
      RUN: begin
        if (!hold) begin
          shift_d = {shift_q[13:0], pix_bit};
          cnt_d   = cnt_q + {14'd0, pix_bit};
          // The 15 earlier bits plus this one form the complete MSB-first word.
          if (addr_q[3:0] == 4'hF) begin
            wr_d    = 1'b1;
            waddr_d = addr_q[13:4];
            wdata_d = {shift_q, pix_bit};
          end
          if (addr_q == 14'h3FFF) begin
            state_d = FLUSH;
            rd_d    = 1'b0;
          end else begin
            addr_d = addr_q + 14'd1;
          end
        end
      end
      FLUSH: begin
        if (!hold) begin
          state_d = FIN;
          done_d  = 1'b1;
        end
      end
      FIN: begin
        state_d = FIN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign res_rd   = rd_q;
  assign res_addr = addr_q;
  assign sti_wr   = wr_q;
  assign sti_addr = waddr_q;
  assign sti_do   = wdata_q;
  assign obj_cnt  = cnt_q;
  assign done     = done_q;

endmodule

// File: tb/tb_res_pack.sv
// tb/tb_res_pack.sv - scoreboard bench for res_pack: expected words queued per run, popped on each write
module tb_res_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  thr;
  logic        hold;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        sti_wr;
  logic [9:0]  sti_addr;
  logic [15:0] sti_do;
  logic [14:0] obj_cnt;
  logic        done;

  int          mode_v;
  logic [25:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  res_pack dut (
    .clk      (clk),
    .reset    (reset),
    .thr      (thr),
    .hold     (hold),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
    .sti_wr   (sti_wr),
    .sti_addr (sti_addr),
    .sti_do   (sti_do),
    .obj_cnt  (obj_cnt),
    .done     (done)
  );

  // Distance-map RAM contents for each image pattern.
  function automatic logic [7:0] pix(input int m, input logic [13:0] a);
    case (m)
      0:       pix = (a == 14'd0) ? 8'd1 : 8'd0;
      1:       pix = a[0] ? 8'd5 : 8'd0;
      default: pix = 8'd255;
    endcase
  endfunction

  assign res_di = pix(mode_v, res_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_run(input int m, input logic [7:0] t, input int stall_len, input int abort_pix);
    int          edges;
    int          done_edge;
    int          stall_left;
    int          nw;
    bit          stalled;
    bit          aborted;
    logic [15:0] word;
    logic [14:0] exp_cnt;
    logic [13:0] k;

    mode_v = m;
    thr    = t;
    exp_q.delete();
    nw      = (abort_pix > 0) ? abort_pix / 16 : 1024;
    exp_cnt = 15'd0;
    word    = 16'd0;
    for (int w = 0; w < 1024; w++) begin
      for (int i = 0; i < 16; i++) begin
        k            = 14'(w * 16 + i);
        word[15 - i] = (pix(m, k) > t);
        exp_cnt      = exp_cnt + 15'(word[15 - i]);
      end
      if (w < nw) exp_q.push_back({10'(w), word});
    end

    @(negedge clk);
    reset = 1'b0;
    hold  = 1'b1;
    #1;
    check("rst_outs", 64'({res_rd, res_addr, sti_wr, sti_addr, sti_do, obj_cnt, done}), 64'd0);
    @(negedge clk);
    check("rst_hold_outs", 64'({res_rd, res_addr, sti_wr, obj_cnt, done}), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("e0_rd_addr", 64'({res_rd, res_addr, done}), 64'({1'b1, 14'd0, 1'b0}));
    hold = 1'b0;

    edges      = 0;
    done_edge  = -1;
    stall_left = 0;
    stalled    = 1'b0;
    aborted    = 1'b0;
    while (done_edge < 0 && edges < 20000 && !aborted) begin
      if (abort_pix > 0 && res_addr == 14'(abort_pix)) begin
        reset = 1'b0;
        #1;
        check("abort_outs", 64'({res_rd, res_addr, sti_wr, sti_addr, sti_do, obj_cnt, done}), 64'd0);
        check("abort_q_empty", 64'(exp_q.size()), 64'd0);
        aborted = 1'b1;
      end else begin
        if (stall_len > 0 && !stalled && res_addr == 14'd20) begin
          stall_left = stall_len;
          stalled    = 1'b1;
        end
        hold = (stall_left > 0);
        @(negedge clk);
        edges++;
        if (hold) begin
          stall_left--;
          check("stall_hold", 64'({sti_wr, res_addr}), 64'({1'b0, 14'd20}));
        end
        if (sti_wr) begin
          if (exp_q.size() == 0) check("extra_write", 64'(sti_wr), 64'd0);
          else check("word", 64'({sti_addr, sti_do}), 64'(exp_q.pop_front()));
          if (sti_addr == 10'd1) check("w1_edge", 64'(edges), 64'(32 + stall_len));
        end
        if (done && done_edge < 0) done_edge = edges;
      end
    end
    hold = 1'b0;

    if (!aborted) begin
      check("done_edge", 64'(done_edge), 64'(16385 + stall_len));
      check("end_state", 64'({res_rd, res_addr, sti_wr, obj_cnt}),
            64'({1'b0, 14'h3FFF, 1'b0, exp_cnt}));
      check("q_drained", 64'(exp_q.size()), 64'd0);
      hold = 1'b1;
      repeat (3) @(negedge clk);
      check("fin_hold", 64'({done, sti_wr, obj_cnt}), 64'({1'b1, 1'b0, exp_cnt}));
      hold = 1'b0;
    end
  endtask

  initial begin
    reset  = 1'b0;
    hold   = 1'b0;
    thr    = 8'd0;
    mode_v = 0;
    do_run(0, 8'd0, 3, 0);
    do_run(1, 8'd4, 0, 5000);
    do_run(1, 8'd4, 0, 0);
    do_run(2, 8'd254, 0, 0);
    do_run(2, 8'd255, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/res_pack.md
RES_PACK -- requirements
Module: res_pack

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and reset.
REQ-002 The ports SHALL be, clock and reset first:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- thr  input  8  object threshold, compared every pixel
- hold  input  1  stall request; when 1 the block does not advance
- res_rd  output  1  read strobe to distance-map RAM
- res_addr  output  14  pixel address, row*128+col
- res_di  input  8  pixel value; asynchronous read of res_addr
- sti_wr  output  1  one-cycle write strobe to bitmap RAM
- sti_addr  output  10  word address, pixel_index>>4
- sti_do  output  16  packed bitmap word
- obj_cnt  output  15  running count of object pixels
- done  output  1  run complete, sticky

Function
REQ-003 Definitions: E0 is the first rising clk edge with reset high; Ek is the k-th edge after E0, counting only edges where hold=0; all outputs are registered.
REQ-004 The FSM SHALL have states IDLE, RUN, FLUSH and FIN; IDLE->RUN at E0; RUN->FLUSH at the edge that samples pixel 16383; FLUSH->FIN on the next edge; FIN holds until reset.
REQ-005 At E0 the block SHALL set res_rd=1 and res_addr=0; at Ek for k=1..16383 it SHALL set res_addr=k.
REQ-006 At Ek+1 the block SHALL sample res_di for address k: bit = (res_di > thr), unsigned 8-bit compare.
REQ-007 Sampled bits SHALL pack MSB-first: pixel k maps to sti_do bit 15-(k mod 16) of word k>>4.
REQ-008 At the edge that samples a pixel with k mod 16 = 15, the block SHALL set sti_wr=1, sti_addr=k>>4 and sti_do to the complete word, all in the same cycle.
REQ-009 sti_wr SHALL be 1 for exactly one cycle per word; words SHALL be written strictly in order 0..1023; sti_addr and sti_do SHALL hold their values between writes.
REQ-010 obj_cnt SHALL increment by 1 at each sampling edge where bit=1; it SHALL hold after completion and cannot wrap (maximum 16384).
REQ-011 At the edge that samples pixel 16383, res_rd SHALL go to 0 and res_addr SHALL hold 16383.
REQ-012 done SHALL go to 1 at the edge after the final write cycle (E16385 with no stalls) and stay 1 until reset.
REQ-013 With hold=1 at an edge, that edge SHALL not sample, not change res_addr, and not count; sti_wr SHALL be 0 after that edge, and any pending word write is deferred to the next edge with hold=0.
REQ-014 hold SHALL have no effect in IDLE (E0 proceeds regardless) and none in FIN.
REQ-015 A change of thr mid-run SHALL affect only pixels sampled at or after the edge where the new value is present.
REQ-016 With no stalls, one run SHALL take exactly 16386 edges (E0..E16385).

Reset
REQ-017 While reset=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the shift register and counters SHALL be cleared.
REQ-018 Reset asserted mid-run SHALL abort immediately with no partial write; after release the run SHALL restart from pixel 0 at the new E0.

Verification
REQ-019 All res_di=0, thr=0 -> 1024 writes of sti_do=16'h0000 at addresses 0..1023 in order; obj_cnt=0; done rises at E16385.
REQ-020 res_di=1 only at pixel 0, thr=0 -> word 0 = 16'h8000, all other words 16'h0000; obj_cnt=1.
REQ-021 res_di=5 at odd addresses and 0 at even, thr=4 -> every word 16'h5555; obj_cnt=8192.
REQ-022 res_di=255 everywhere: thr=255 gives all words 16'h0000 and obj_cnt=0; thr=254 gives all words 16'hFFFF and obj_cnt=16384.
REQ-023 hold=1 for 3 edges while pixel 20 is pending -> write data identical to the unstalled run; word 1 written 3 cycles later; done rises 3 cycles later.
REQ-024 reset pulsed low at pixel 5000 -> outputs 0 within the reset period; after release res_addr restarts at 0 and word 0 is rewritten; the full 1024-word sequence completes.
